// File: rtl/coin_keeper_if.sv
// Game-input/coin-status bundle between level logic and coin_keeper.
// The master side drives player state and game events; the slave side reports coin progress.
interface coin_keeper_if;
  logic       frame_clk;
  logic       game_start;
  logic       level_end;
  logic       game_over;
  logic [9:0] Player_X;
  logic [9:0] Player_Y;
  logic [11:0] Scroll_X;
  logic [2:0] CoinStatus;
  logic [1:0] Coin_Count;
  logic       coin_pulse;
  logic       Win;
  logic       Lose;

  modport master (
    output frame_clk, game_start, level_end, game_over, Player_X, Player_Y, Scroll_X,
    input  CoinStatus, Coin_Count, coin_pulse, Win, Lose
  );

  modport slave (
    input  frame_clk, game_start, level_end, game_over, Player_X, Player_Y, Scroll_X,
    output CoinStatus, Coin_Count, coin_pulse, Win, Lose
  );
endinterface

// File: rtl/coin_keeper.sv
// Tracks collection of the three level coins once per frame and freezes the tally at win/lose.
// Collision uses world-space X (scroll + screen X) and screen-space Y with strict box overlap.
module coin_keeper #(
  parameter logic [11:0] COIN1_X   = 12'd400,
  parameter logic [9:0]  COIN1_Y   = 10'd300,
  parameter logic [11:0] COIN2_X   = 12'd800,
  parameter logic [9:0]  COIN2_Y   = 10'd250,
  parameter logic [11:0] COIN3_X   = 12'd1200,
  parameter logic [9:0]  COIN3_Y   = 10'd300,
  parameter logic [9:0]  COIN_SIZE = 10'd16,
  parameter logic [9:0]  PLAYER_W  = 10'd16,
  parameter logic [9:0]  PLAYER_H  = 10'd32
) (
  input  logic Clk,
  input  logic Reset,
  coin_keeper_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PLAYING, WON, LOST} state_e;

  state_e     state_q, state_d;
  logic [2:0] coin_q, coin_d;
  logic [1:0] count_q, count_d;
  logic       pulse_q, pulse_d;
  logic       frame_clk_delayed_q;

  logic       tick;
  logic [12:0] pwx;
  logic [2:0] hit;
  logic [2:0] cleared;

  assign tick = bus.frame_clk & ~frame_clk_delayed_q;
  assign pwx  = {1'b0, bus.Scroll_X} + {3'b000, bus.Player_X};

  // Widened sums (13-bit X, 11-bit Y) so no edge comparison can wrap.
  function automatic logic overlaps(input logic [12:0] px, input logic [9:0] py,
                                    input logic [11:0] cx, input logic [9:0] cy);
    logic x_ok;
    logic y_ok;
    x_ok = (px < ({1'b0, cx} + {3'b000, COIN_SIZE})) &&
           ({1'b0, cx} < (px + {3'b000, PLAYER_W}));
    y_ok = ({1'b0, py} < ({1'b0, cy} + {1'b0, COIN_SIZE})) &&
           ({1'b0, cy} < ({1'b0, py} + {1'b0, PLAYER_H}));
    return x_ok && y_ok;
  endfunction

  assign hit[0] = overlaps(pwx, bus.Player_Y, COIN1_X, COIN1_Y);
  assign hit[1] = overlaps(pwx, bus.Player_Y, COIN2_X, COIN2_Y);
  assign hit[2] = overlaps(pwx, bus.Player_Y, COIN3_X, COIN3_Y);
  assign cleared = hit & coin_q;

  always_comb begin
    state_d = state_q;
    coin_d  = coin_q;
    pulse_d = 1'b0;
    if (bus.game_start) begin
      state_d = PLAYING;
      coin_d  = 3'b111;
    end else begin
      unique case (state_q)
        PLAYING: begin
          // A tick on the same cycle as level_end/game_over still commits its hits.
          if (tick) begin
            coin_d  = coin_q & ~cleared;
            pulse_d = |cleared;
          end
          if (bus.game_over) begin
            state_d = LOST;
          end else if (bus.level_end) begin
            state_d = WON;
          end
        end
        default: ;
      endcase
    end
    count_d = {1'b0, ~coin_d[0]} + {1'b0, ~coin_d[1]} + {1'b0, ~coin_d[2]};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q             <= IDLE;
      coin_q              <= 3'b111;
      count_q             <= 2'd0;
      pulse_q             <= 1'b0;
      frame_clk_delayed_q <= 1'b0;
    end else begin
      state_q             <= state_d;
      coin_q              <= coin_d;
      count_q             <= count_d;
      pulse_q             <= pulse_d;
      frame_clk_delayed_q <= bus.frame_clk;
    end
  end

  assign bus.CoinStatus = coin_q;
  assign bus.Coin_Count = count_q;
  assign bus.coin_pulse = pulse_q;
  assign bus.Win        = (state_q == WON);
  assign bus.Lose       = (state_q == LOST);

endmodule

// File: tb/tb_coin_keeper.sv
// Directed bench for coin_keeper: a box-overlap game model is compared every cycle,
// and hand-derived literal expectations pin the key scenarios.
module tb_coin_keeper;
  logic Clk = 1'b0;
  logic Reset;

  coin_keeper_if cif ();

  coin_keeper dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (cif)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  // Game model: mode 0 idle, 1 playing, 2 won, 3 lost
  int       m_mode = 0;
  bit [2:0] m_coins = 3'b111;
  bit       m_pulse = 1'b0;
  bit       m_prev_fc = 1'b0;
  bit       m_tick;
  int       cx [3] = '{400, 800, 1200};
  int       cy [3] = '{300, 250, 300};

  function automatic bit touches(input int i);
    int wx;
    int py;
    wx = int'(cif.Scroll_X) + int'(cif.Player_X);
    py = int'(cif.Player_Y);
    return (wx < cx[i] + 16) && (cx[i] < wx + 16) && (py < cy[i] + 16) && (cy[i] < py + 32);
  endfunction

  always @(posedge Clk) begin
    m_tick    = cif.frame_clk && !m_prev_fc;
    m_prev_fc = cif.frame_clk;
    m_pulse   = 1'b0;
    if (Reset) begin
      m_mode    = 0;
      m_coins   = 3'b111;
      m_prev_fc = 1'b0;
    end else if (cif.game_start) begin
      m_mode  = 1;
      m_coins = 3'b111;
    end else if (m_mode == 1) begin
      if (m_tick) begin
        for (int i = 0; i < 3; i++) begin
          if (m_coins[i] && touches(i)) begin
            m_coins[i] = 1'b0;
            m_pulse    = 1'b1;
          end
        end
      end
      if (cif.game_over) m_mode = 3;
      else if (cif.level_end) m_mode = 2;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_on) begin
      checkOutput("model CoinStatus", int'(cif.CoinStatus), int'(m_coins));
      checkOutput("model Coin_Count", int'(cif.Coin_Count), 3 - $countones(m_coins));
      checkOutput("model coin_pulse", int'(cif.coin_pulse), int'(m_pulse));
      checkOutput("model Win", int'(cif.Win), int'(m_mode == 2));
      checkOutput("model Lose", int'(cif.Lose), int'(m_mode == 3));
    end
  end

  task automatic applyStimulus(input bit rst, input bit gs, input bit le, input bit go,
                               input bit fc, input int cycles);
    Reset          = rst;
    cif.game_start = gs;
    cif.level_end  = le;
    cif.game_over  = go;
    cif.frame_clk  = fc;
    repeat (cycles) begin
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic setPos(input int sx, input int px, input int py);
    cif.Scroll_X = 12'(sx);
    cif.Player_X = 10'(px);
    cif.Player_Y = 10'(py);
  endtask

  task automatic expectOutputs(input string tag, input int coins, input int cnt,
                               input int pulse, input int win, input int lose);
    checkOutput({tag, " CoinStatus"}, int'(cif.CoinStatus), coins);
    checkOutput({tag, " Coin_Count"}, int'(cif.Coin_Count), cnt);
    checkOutput({tag, " coin_pulse"}, int'(cif.coin_pulse), pulse);
    checkOutput({tag, " Win"}, int'(cif.Win), win);
    checkOutput({tag, " Lose"}, int'(cif.Lose), lose);
  endtask

  initial begin
    setPos(0, 100, 300);
    applyStimulus(1, 0, 0, 0, 0, 1);
    cmp_on = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 2);
    expectOutputs("reset", 7, 0, 0, 0, 0);

    // Start level far from any coin; a frame tick collects nothing
    applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    expectOutputs("no hit", 7, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2);

    // World X 395 overlaps coin 1
    setPos(390, 5, 290);
    applyStimulus(0, 0, 0, 0, 1, 1);
    expectOutputs("coin1 hit", 6, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    expectOutputs("coin1 pulse end", 6, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    expectOutputs("coin1 retick", 6, 1, 0, 0, 0);

    // Edge touch at world X 784 against coin 2 (800), then one pixel further
    setPos(700, 84, 250);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    expectOutputs("edge touch", 6, 1, 0, 0, 0);
    setPos(700, 85, 250);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    expectOutputs("edge overlap", 4, 2, 1, 0, 0);

    setPos(1100, 100, 300);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    expectOutputs("coin3 hit", 0, 3, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 1);
    expectOutputs("won", 0, 3, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    expectOutputs("won frozen", 0, 3, 0, 1, 0);

    // Restart, then game_over and level_end together: lose wins priority
    applyStimulus(0, 1, 0, 0, 0, 1);
    expectOutputs("restart", 7, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 1);
    expectOutputs("lost", 7, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    expectOutputs("lost frozen", 7, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 1);
    expectOutputs("restart2", 7, 0, 0, 0, 0);

    applyStimulus(0, 0, 1, 0, 1, 1);
    expectOutputs("tick with level_end", 3, 1, 1, 1, 0);

    // game_start overrides a same-cycle hitting tick
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1, 1);
    expectOutputs("start over tick", 7, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    expectOutputs("hit after start", 3, 1, 1, 0, 0);

    // Reset on the tick cycle discards the collision
    applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1, 1);
    expectOutputs("reset mid tick", 7, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    expectOutputs("idle no collect", 7, 0, 0, 0, 0);

    // Reset the cycle after a hitting tick
    applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    expectOutputs("hit before reset", 3, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 1);
    expectOutputs("reset after hit", 7, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    expectOutputs("idle after reset", 7, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    expectOutputs("collect after start", 3, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2);

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/coin_keeper.md
Name: coin_keeper

Overview:
- Game-logic stage that tracks collection of the three level coins and drives `CoinStatus[2:0]` to the star score display.
- Every frame it tests the player bounding box against each uncollected coin in world coordinates, then latches collected coins.
- Runs a play/win/lose state machine so the coin tally freezes when the level ends.

Parameters:
- COIN1_X, 12'd400, world X of coin 1 (top-left)
- COIN1_Y, 10'd300, screen Y of coin 1
- COIN2_X, 12'd800, world X of coin 2
- COIN2_Y, 10'd250, screen Y of coin 2
- COIN3_X, 12'd1200, world X of coin 3
- COIN3_Y, 10'd300, screen Y of coin 3
- COIN_SIZE, 10'd16, coin square edge in pixels
- PLAYER_W, 10'd16, player box width
- PLAYER_H, 10'd32, player box height

Ports:
- Clk  input  1  50 MHz system clock
- Reset  input  1  synchronous, active-high reset
- frame_clk  input  1  vertical-sync-rate frame clock, asynchronous-looking level; only its rising edge is used
- game_start  input  1  one-Clk pulse: begin or restart the level
- level_end  input  1  level: player reached finish line
- game_over  input  1  level: player died
- Player_X  input  10  player screen X (top-left)
- Player_Y  input  10  player screen Y (top-left)
- Scroll_X  input  12  world X of screen column 0
- CoinStatus  output  3  bit i = 1 coin i+1 still present, 0 collected; consumed by star display
- Coin_Count  output  2  number of zero bits in CoinStatus
- coin_pulse  output  1  one-Clk strobe when any coin is collected
- Win  output  1  high in WON state
- Lose  output  1  high in LOST state

Behaviour:
- One clock domain (Clk); reset is synchronous and active-high.
- Reset values:
  - CoinStatus=3'b111, Coin_Count=0, coin_pulse=0, Win=0, Lose=0
  - state=IDLE
  - frame_clk_delayed register=0
- Frame tick:
  - frame_clk_delayed <= frame_clk every Clk.
  - tick = frame_clk & ~frame_clk_delayed.
  - Exactly one tick per rising edge, asserted for one Clk.
- Collision test, combinational:
  - PWX = {1'b0,Scroll_X} + Player_X, computed 13-bit with no wrap.
  - hit_i when PWX < CX_i+COIN_SIZE and CX_i < PWX+PLAYER_W and Player_Y < CY_i+COIN_SIZE and CY_i < Player_Y+PLAYER_H.
  - All sums are 13-bit (X) and 11-bit (Y) so nothing overflows.
  - Boundaries are strict: edge-touching boxes do not hit.
- States:
  - IDLE: outputs at reset values. game_start -> PLAYING.
  - PLAYING: on tick, for each i with hit_i && CoinStatus[i]: CoinStatus[i] <= 0. coin_pulse=1 the following Clk if any bit cleared. Multiple coins may clear on the same tick.
    - game_over -> LOST.
    - Else level_end -> WON.
    - game_over has priority when both are high.
    - A tick coinciding with the level_end/game_over cycle still commits its collisions before freezing.
  - WON: Win=1, CoinStatus frozen. game_start -> PLAYING.
  - LOST: Lose=1, CoinStatus frozen. game_start -> PLAYING.
- game_start in any state:
  - Next Clk: state=PLAYING, CoinStatus=3'b111, Win=Lose=0.
  - Overrides a same-cycle tick, level_end or game_over.
- Collected coins never reappear except via game_start or Reset. A coin already 0 yields no pulse.
- Coin_Count is registered, updated the same edge as CoinStatus (popcount of ~CoinStatus, next value); range 0..3.
- Latency: collision visible on CoinStatus 1 Clk after tick cycle; coin_pulse aligned with that update.
- Reset mid-PLAYING or mid-tick: reset values next Clk, any pending collision discarded.
- No collision evaluation outside PLAYING.

Test Plan:
- Reset, then game_start with Scroll_X=0, Player_X=100, Player_Y=300, toggle frame_clk -> CoinStatus=111, Coin_Count=0, no coin_pulse.
- PLAYING, Scroll_X=390, Player_X=5, Player_Y=290 (PWX=395 overlaps coin 1), frame_clk rise -> CoinStatus=110 and coin_pulse=1 for exactly one Clk one cycle after the tick. Repeated ticks: no further pulses.
- Edge touch: PWX=384 (PWX+16=400=CX1), Y overlapping -> no hit. PWX=385 -> hit.
- Collect coins 2 and 3, then level_end=1 -> Win=1, CoinStatus=000, Coin_Count=3. Further overlapping ticks change nothing.
- Same Clk: game_over=1 and level_end=1 -> Lose=1, Win=0. game_start -> PLAYING, CoinStatus=111, Lose=0.
- Reset asserted the Clk after a hitting tick -> CoinStatus=111, coin_pulse=0, IDLE. game_start required before any collection.
